// File: rtl/vliw_wb_pkg.sv
// Shared constants for the EX->WB writeback stage of the two-slot VLIW core.
// Contents:
//   DATA_W_DEF / RADDR_W_DEF / CNT_W_DEF : default widths for the stage
//   NUM_RD_PORTS                         : register-file read ports that can be bypassed
//   RP_*                                 : index of each read port in rd_addr/rf_data/byp_data
package vliw_wb_pkg;

  localparam int DATA_W_DEF   = 32;
  localparam int RADDR_W_DEF  = 3;
  localparam int CNT_W_DEF    = 8;

  localparam int NUM_RD_PORTS = 4;

  // Read-port order as wired from the register file.
  localparam int RP_MEM_RN = 0;
  localparam int RP_MEM_RD = 1;
  localparam int RP_ALU_RM = 2;
  localparam int RP_ALU_RN = 3;

endpackage : vliw_wb_pkg

// File: rtl/wb_bypass_mux.sv
// One read port's bypass select for the writeback stage.
// When BYPASS_EN=1 the read data is replaced by an in-flight write to the same
// register (MEM write first, then ALU write); otherwise rf_data_i passes straight
// through and no comparators exist.
// Ports:
//   rd_addr_i            read index presented to the register file
//   rf_data_i            raw register-file read data
//   mem_we_i/_rd_i/_data_i  registered MEM-slot write
//   alu_we_i/_rd_i/_data_i  registered ALU-slot write
//   byp_data_o           read data after bypass
module wb_bypass_mux #(
  parameter int DATA_W    = 32,
  parameter int RADDR_W   = 3,
  parameter bit BYPASS_EN = 1'b0
) (
  input  logic [RADDR_W-1:0] rd_addr_i,
  input  logic [DATA_W-1:0]  rf_data_i,
  input  logic               mem_we_i,
  input  logic [RADDR_W-1:0] mem_rd_i,
  input  logic [DATA_W-1:0]  mem_data_i,
  input  logic               alu_we_i,
  input  logic [RADDR_W-1:0] alu_rd_i,
  input  logic [DATA_W-1:0]  alu_data_i,
  output logic [DATA_W-1:0]  byp_data_o
);

  if (BYPASS_EN) begin : g_bypass
    logic mem_hit;
    logic alu_hit;

    assign mem_hit = mem_we_i && (mem_rd_i == rd_addr_i);
    assign alu_hit = alu_we_i && (alu_rd_i == rd_addr_i);

    // MEM is checked first: on a same-rd pair the ALU write was already
    // dropped at capture, so this order just mirrors who wins the register.
    always_comb begin
      byp_data_o = rf_data_i;
      if (mem_hit) begin
        byp_data_o = mem_data_i;
      end else if (alu_hit) begin
        byp_data_o = alu_data_i;
      end
    end
  end else begin : g_passthru
    logic unused_bypass_in;

    assign byp_data_o       = rf_data_i;
    assign unused_bypass_in = ^{rd_addr_i, mem_we_i, mem_rd_i, mem_data_i,
                                alu_we_i, alu_rd_i, alu_data_i};
  end

endmodule : wb_bypass_mux

// File: rtl/wb_writeback_stage.sv
// EX->WB pipeline stage of the two-slot VLIW core. Registers the ALU-slot and
// MEM-slot results, resolves same-destination conflicts (MEM slot wins) and
// drives the p4_* write ports of the register file.
//
// Optional feature: define WB_BYPASS_EN to forward the registered writes onto
// the four read ports (byp_data). Without it byp_data = rf_data.
//
// Ports:
//   clk, reset (async, active-high)
//   stall            hold every stage register; conflict pulse drops
//   flush            squash the incoming bundle; write enables drop, rest holds
//   ex_alu_*/ex_mem_*  incoming bundle from EX
//   p4_alu_*/alu_writeData, p4_mem_*/mem_writeData  register-file write ports
//   conflict         one-cycle pulse when a same-rd pair was captured
//   conflict_cnt     saturating count of captured conflicts
//   rd_addr/rf_data  register-file read indices and raw read data
//   byp_data         read data after bypass
//
// Control semantics: there is no valid/ready handshake here. The write enables
// act as the valid qualifier towards the register file and are accepted
// unconditionally on the next edge. Priority at the clock edge is
// reset > flush > stall > capture; flush and stall never advance the counter
// and never let the conflict pulse persist.
module wb_writeback_stage
  import vliw_wb_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int RADDR_W = RADDR_W_DEF,
  parameter int CNT_W   = CNT_W_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               stall,
  input  logic               flush,
  input  logic               ex_alu_regWrite,
  input  logic [RADDR_W-1:0] ex_alu_rd,
  input  logic [DATA_W-1:0]  ex_alu_result,
  input  logic               ex_mem_regWrite,
  input  logic [RADDR_W-1:0] ex_mem_rd,
  input  logic [DATA_W-1:0]  ex_mem_data,
  output logic               p4_alu_regWrite,
  output logic [RADDR_W-1:0] p4_alu_rd,
  output logic [DATA_W-1:0]  alu_writeData,
  output logic               p4_mem_regWrite,
  output logic [RADDR_W-1:0] p4_mem_rd,
  output logic [DATA_W-1:0]  mem_writeData,
  output logic               conflict,
  output logic [CNT_W-1:0]   conflict_cnt,
  input  logic [RADDR_W-1:0] rd_addr  [NUM_RD_PORTS],
  input  logic [DATA_W-1:0]  rf_data  [NUM_RD_PORTS],
  output logic [DATA_W-1:0]  byp_data [NUM_RD_PORTS]
);

`ifdef WB_BYPASS_EN
  localparam bit BYPASS_EN = 1'b1;
`else
  localparam bit BYPASS_EN = 1'b0;
`endif

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic               alu_we_q,   alu_we_d;
  logic [RADDR_W-1:0] alu_rd_q,   alu_rd_d;
  logic [DATA_W-1:0]  alu_data_q, alu_data_d;
  logic               mem_we_q,   mem_we_d;
  logic [RADDR_W-1:0] mem_rd_q,   mem_rd_d;
  logic [DATA_W-1:0]  mem_data_q, mem_data_d;
  logic               conflict_q, conflict_d;
  logic [CNT_W-1:0]   cnt_q,      cnt_d;

  logic               same_rd_hit;

  // Both slots target the same register in the incoming bundle.
  assign same_rd_hit = ex_alu_regWrite && ex_mem_regWrite && (ex_alu_rd == ex_mem_rd);

  always_comb begin
    alu_we_d   = alu_we_q;
    alu_rd_d   = alu_rd_q;
    alu_data_d = alu_data_q;
    mem_we_d   = mem_we_q;
    mem_rd_d   = mem_rd_q;
    mem_data_d = mem_data_q;
    conflict_d = 1'b0;
    cnt_d      = cnt_q;

    if (flush) begin
      // Index/data are left alone: a disabled write is a no-op downstream.
      alu_we_d = 1'b0;
      mem_we_d = 1'b0;
    end else if (!stall) begin
      alu_we_d   = ex_alu_regWrite && !same_rd_hit;
      alu_rd_d   = ex_alu_rd;
      alu_data_d = ex_alu_result;
      mem_we_d   = ex_mem_regWrite;
      mem_rd_d   = ex_mem_rd;
      mem_data_d = ex_mem_data;
      if (same_rd_hit) begin
        conflict_d = 1'b1;
        if (cnt_q != CNT_MAX) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      alu_we_q   <= 1'b0;
      alu_rd_q   <= '0;
      alu_data_q <= '0;
      mem_we_q   <= 1'b0;
      mem_rd_q   <= '0;
      mem_data_q <= '0;
      conflict_q <= 1'b0;
      cnt_q      <= '0;
    end else begin
      alu_we_q   <= alu_we_d;
      alu_rd_q   <= alu_rd_d;
      alu_data_q <= alu_data_d;
      mem_we_q   <= mem_we_d;
      mem_rd_q   <= mem_rd_d;
      mem_data_q <= mem_data_d;
      conflict_q <= conflict_d;
      cnt_q      <= cnt_d;
    end
  end

  assign p4_alu_regWrite = alu_we_q;
  assign p4_alu_rd       = alu_rd_q;
  assign alu_writeData   = alu_data_q;
  assign p4_mem_regWrite = mem_we_q;
  assign p4_mem_rd       = mem_rd_q;
  assign mem_writeData   = mem_data_q;
  assign conflict        = conflict_q;
  assign conflict_cnt    = cnt_q;

  for (genvar i = 0; i < NUM_RD_PORTS; i++) begin : g_rd_port
    wb_bypass_mux #(
      .DATA_W    (DATA_W),
      .RADDR_W   (RADDR_W),
      .BYPASS_EN (BYPASS_EN)
    ) u_bypass_mux (
      .rd_addr_i  (rd_addr[i]),
      .rf_data_i  (rf_data[i]),
      .mem_we_i   (mem_we_q),
      .mem_rd_i   (mem_rd_q),
      .mem_data_i (mem_data_q),
      .alu_we_i   (alu_we_q),
      .alu_rd_i   (alu_rd_q),
      .alu_data_i (alu_data_q),
      .byp_data_o (byp_data[i])
    );
  end

endmodule : wb_writeback_stage

// File: tb/tb_wb_writeback_stage.sv
// Directed bench for wb_writeback_stage. A second instance with CNT_W=2 shares
// all inputs and is used for the counter saturation case.
module tb_wb_writeback_stage;
  import vliw_wb_pkg::*;

  localparam int DATA_W  = 32;
  localparam int RADDR_W = 3;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               reset;
  logic               stall;
  logic               flush;
  logic               ex_alu_regWrite;
  logic [RADDR_W-1:0] ex_alu_rd;
  logic [DATA_W-1:0]  ex_alu_result;
  logic               ex_mem_regWrite;
  logic [RADDR_W-1:0] ex_mem_rd;
  logic [DATA_W-1:0]  ex_mem_data;
  logic [RADDR_W-1:0] rd_addr  [NUM_RD_PORTS];
  logic [DATA_W-1:0]  rf_data  [NUM_RD_PORTS];

  logic               p4_alu_regWrite;
  logic [RADDR_W-1:0] p4_alu_rd;
  logic [DATA_W-1:0]  alu_writeData;
  logic               p4_mem_regWrite;
  logic [RADDR_W-1:0] p4_mem_rd;
  logic [DATA_W-1:0]  mem_writeData;
  logic               conflict;
  logic [7:0]         conflict_cnt;
  logic [DATA_W-1:0]  byp_data [NUM_RD_PORTS];

  logic               s_alu_we, s_mem_we, s_conflict;
  logic [RADDR_W-1:0] s_alu_rd, s_mem_rd;
  logic [DATA_W-1:0]  s_alu_data, s_mem_data;
  logic [1:0]         s_cnt;
  logic [DATA_W-1:0]  s_byp [NUM_RD_PORTS];

  wb_writeback_stage #(.DATA_W(DATA_W), .RADDR_W(RADDR_W), .CNT_W(8)) dut (
    .clk             (clk),
    .reset           (reset),
    .stall           (stall),
    .flush           (flush),
    .ex_alu_regWrite (ex_alu_regWrite),
    .ex_alu_rd       (ex_alu_rd),
    .ex_alu_result   (ex_alu_result),
    .ex_mem_regWrite (ex_mem_regWrite),
    .ex_mem_rd       (ex_mem_rd),
    .ex_mem_data     (ex_mem_data),
    .p4_alu_regWrite (p4_alu_regWrite),
    .p4_alu_rd       (p4_alu_rd),
    .alu_writeData   (alu_writeData),
    .p4_mem_regWrite (p4_mem_regWrite),
    .p4_mem_rd       (p4_mem_rd),
    .mem_writeData   (mem_writeData),
    .conflict        (conflict),
    .conflict_cnt    (conflict_cnt),
    .rd_addr         (rd_addr),
    .rf_data         (rf_data),
    .byp_data        (byp_data)
  );

  wb_writeback_stage #(.DATA_W(DATA_W), .RADDR_W(RADDR_W), .CNT_W(2)) dut_sat (
    .clk             (clk),
    .reset           (reset),
    .stall           (stall),
    .flush           (flush),
    .ex_alu_regWrite (ex_alu_regWrite),
    .ex_alu_rd       (ex_alu_rd),
    .ex_alu_result   (ex_alu_result),
    .ex_mem_regWrite (ex_mem_regWrite),
    .ex_mem_rd       (ex_mem_rd),
    .ex_mem_data     (ex_mem_data),
    .p4_alu_regWrite (s_alu_we),
    .p4_alu_rd       (s_alu_rd),
    .alu_writeData   (s_alu_data),
    .p4_mem_regWrite (s_mem_we),
    .p4_mem_rd       (s_mem_rd),
    .mem_writeData   (s_mem_data),
    .conflict        (s_conflict),
    .conflict_cnt    (s_cnt),
    .rd_addr         (rd_addr),
    .rf_data         (rf_data),
    .byp_data        (s_byp)
  );

  // scoreboard counters
  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // driver tasks
  task automatic drive_ex(input logic a_we, input logic [RADDR_W-1:0] a_rd, input logic [DATA_W-1:0] a_d,
                          input logic m_we, input logic [RADDR_W-1:0] m_rd, input logic [DATA_W-1:0] m_d);
    ex_alu_regWrite = a_we;
    ex_alu_rd       = a_rd;
    ex_alu_result   = a_d;
    ex_mem_regWrite = m_we;
    ex_mem_rd       = m_rd;
    ex_mem_data     = m_d;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_stage(input string tag, input logic a_we, input logic [RADDR_W-1:0] a_rd,
                             input logic [DATA_W-1:0] a_d, input logic m_we,
                             input logic [RADDR_W-1:0] m_rd, input logic [DATA_W-1:0] m_d,
                             input logic cf, input logic [7:0] cnt);
    check({tag, ".alu_we"},   32'(p4_alu_regWrite), 32'(a_we));
    check({tag, ".alu_rd"},   32'(p4_alu_rd),       32'(a_rd));
    check({tag, ".alu_data"}, alu_writeData,        a_d);
    check({tag, ".mem_we"},   32'(p4_mem_regWrite), 32'(m_we));
    check({tag, ".mem_rd"},   32'(p4_mem_rd),       32'(m_rd));
    check({tag, ".mem_data"}, mem_writeData,        m_d);
    check({tag, ".conflict"}, 32'(conflict),        32'(cf));
    check({tag, ".cnt"},      32'(conflict_cnt),    32'(cnt));
  endtask

  logic [DATA_W-1:0] exp_byp;

  initial begin
    reset = 1'b1;
    stall = 1'b0;
    flush = 1'b0;
    for (int i = 0; i < NUM_RD_PORTS; i++) begin
      rd_addr[i] = '0;
      rf_data[i] = '0;
    end
    // Active bundle (including a conflict) while reset is held.
    drive_ex(1'b1, 3'd4, 32'hDEAD, 1'b1, 3'd4, 32'hBEEF);

    // 1: asynchronous reset, before and after clock edges
    #2;
    check_stage("rst_async", 1'b0, 3'd0, 32'h0, 1'b0, 3'd0, 32'h0, 1'b0, 8'd0);
    tick();
    tick();
    check_stage("rst_held", 1'b0, 3'd0, 32'h0, 1'b0, 3'd0, 32'h0, 1'b0, 8'd0);
    check("rst_held.sat_cnt", 32'(s_cnt), 32'd0);

    // 2: release reset, distinct destinations -> both writes
    reset = 1'b0;
    drive_ex(1'b1, 3'd3, 32'h11, 1'b1, 3'd5, 32'h22);
    tick();
    check_stage("two_writes", 1'b1, 3'd3, 32'h11, 1'b1, 3'd5, 32'h22, 1'b0, 8'd0);

    // 3: same destination -> MEM wins, pulse, count 1
    drive_ex(1'b1, 3'd4, 32'h33, 1'b1, 3'd4, 32'h44);
    tick();
    check_stage("conflict1", 1'b0, 3'd4, 32'h33, 1'b1, 3'd4, 32'h44, 1'b1, 8'd1);
    check("conflict1.sat_cnt", 32'(s_cnt), 32'd1);

    // ALU only -> pulse gone, count holds
    drive_ex(1'b1, 3'd1, 32'h01, 1'b0, 3'd2, 32'h02);
    tick();
    check_stage("alu_only", 1'b1, 3'd1, 32'h01, 1'b0, 3'd2, 32'h02, 1'b0, 8'd1);

    // Four back-to-back conflicts: five in total
    for (int i = 0; i < 4; i++) begin
      drive_ex(1'b1, 3'd4, 32'h60 + 32'(i), 1'b1, 3'd4, 32'h70 + 32'(i));
      tick();
      check("sat_loop.conflict", 32'(conflict), 32'd1);
    end
    check_stage("after5", 1'b0, 3'd4, 32'h63, 1'b1, 3'd4, 32'h73, 1'b1, 8'd5);
    check("after5.sat_cnt", 32'(s_cnt), 32'd3);

    // 4: flush with stall and a valid conflicting bundle -> enables drop, rest holds
    flush = 1'b1;
    stall = 1'b1;
    drive_ex(1'b1, 3'd2, 32'hF1, 1'b1, 3'd2, 32'hF2);
    tick();
    check_stage("flush", 1'b0, 3'd4, 32'h63, 1'b0, 3'd4, 32'h73, 1'b0, 8'd5);
    check("flush.sat_cnt", 32'(s_cnt), 32'd3);

    // Capture a conflict, then stall: pulse must not repeat
    flush = 1'b0;
    stall = 1'b0;
    drive_ex(1'b1, 3'd1, 32'hC1, 1'b1, 3'd1, 32'hC2);
    tick();
    check_stage("conflict6", 1'b0, 3'd1, 32'hC1, 1'b1, 3'd1, 32'hC2, 1'b1, 8'd6);
    stall = 1'b1;
    tick();
    check_stage("stall_after_cf", 1'b0, 3'd1, 32'hC1, 1'b1, 3'd1, 32'hC2, 1'b0, 8'd6);

    // 5a: MEM rd=2 0xAA, ALU rd=2 blocked
    stall = 1'b0;
    drive_ex(1'b1, 3'd2, 32'h0B, 1'b1, 3'd2, 32'hAA);
    tick();
    check_stage("byp_cf", 1'b0, 3'd2, 32'h0B, 1'b1, 3'd2, 32'hAA, 1'b1, 8'd7);
    rd_addr[RP_ALU_RN] = 3'd2;
    rf_data[RP_ALU_RN] = 32'h0;
    rd_addr[RP_ALU_RM] = 3'd2;
    rf_data[RP_ALU_RM] = 32'h5;
    #1;
`ifdef WB_BYPASS_EN
    exp_byp = 32'hAA;
`else
    exp_byp = 32'h0;
`endif
    check("byp_cf.port3", byp_data[RP_ALU_RN], exp_byp);
`ifdef WB_BYPASS_EN
    exp_byp = 32'hAA;
`else
    exp_byp = 32'h5;
`endif
    check("byp_cf.port2", byp_data[RP_ALU_RM], exp_byp);

    // Both writes valid, then stall for 3 cycles with a different conflicting bundle
    drive_ex(1'b1, 3'd6, 32'h55, 1'b1, 3'd2, 32'hAA);
    tick();
    check_stage("load_hold", 1'b1, 3'd6, 32'h55, 1'b1, 3'd2, 32'hAA, 1'b0, 8'd7);
    stall = 1'b1;
    drive_ex(1'b1, 3'd7, 32'h99, 1'b1, 3'd7, 32'h98);
    for (int i = 0; i < 3; i++) begin
      tick();
      check_stage("stall_hold", 1'b1, 3'd6, 32'h55, 1'b1, 3'd2, 32'hAA, 1'b0, 8'd7);
    end

    // 5b: read ports against the held writes
    rd_addr[RP_MEM_RN] = 3'd6;
    rf_data[RP_MEM_RN] = 32'h1234;
    rd_addr[RP_MEM_RD] = 3'd3;
    rf_data[RP_MEM_RD] = 32'h777;
    rd_addr[RP_ALU_RN] = 3'd2;
    rf_data[RP_ALU_RN] = 32'h0;
    #1;
`ifdef WB_BYPASS_EN
    exp_byp = 32'h55;
`else
    exp_byp = 32'h1234;
`endif
    check("byp_alu.port0", byp_data[RP_MEM_RN], exp_byp);
    check("byp_miss.port1", byp_data[RP_MEM_RD], 32'h777);
`ifdef WB_BYPASS_EN
    exp_byp = 32'hAA;
`else
    exp_byp = 32'h0;
`endif
    check("byp_mem.port3", byp_data[RP_ALU_RN], exp_byp);

    // Reset asserted mid stall+flush: stage empties at once
    flush = 1'b1;
    reset = 1'b1;
    #1;
    check_stage("rst_mid", 1'b0, 3'd0, 32'h0, 1'b0, 3'd0, 32'h0, 1'b0, 8'd0);
    check("rst_mid.sat_cnt", 32'(s_cnt), 32'd0);
    tick();
    check_stage("rst_mid_edge", 1'b0, 3'd0, 32'h0, 1'b0, 3'd0, 32'h0, 1'b0, 8'd0);

    // Release: first edge captures
    reset = 1'b0;
    flush = 1'b0;
    stall = 1'b0;
    drive_ex(1'b1, 3'd3, 32'h11, 1'b0, 3'd0, 32'h0);
    tick();
    check_stage("post_rst", 1'b1, 3'd3, 32'h11, 1'b0, 3'd0, 32'h0, 1'b0, 8'd0);

    // final report
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Safety net so the run always terminates.
  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule : tb_wb_writeback_stage
